easyaxi_mst_ar: RTL

//  AXI read-address (AR) channel master: issues a programmed run of REQ_NUM AR requests

---
 rtl/easyaxi_mst_ar_pkg.sv | 14 +
 rtl/easyaxi_mst_ar_stall_timer.sv | 45 ++++
 rtl/easyaxi_mst_ar.sv | 127 ++++++++++++
 3 files changed

// File: rtl/easyaxi_mst_ar_pkg.sv
// easyaxi_mst_ar_pkg
//   Shared definitions for the easy_axi master channels: default AXI ID/address
//   widths and the master FSM state encoding (reusable by an R-channel master).
package easyaxi_mst_ar_pkg;

    localparam int unsigned EASYAXI_ID_WIDTH   = 4;
    localparam int unsigned EASYAXI_ADDR_WIDTH = 32;

    typedef enum logic {
        EASYAXI_MST_IDLE  = 1'b0,
        EASYAXI_MST_ISSUE = 1'b1
    } easyaxi_mst_state_e;

endpackage

// File: rtl/easyaxi_mst_ar_stall_timer.sv
// easyaxi_stall_timer
//   Counts consecutive stall cycles and raises a sticky error once TIMEOUT_CYC
//   consecutive stalls have been seen. Reusable on AW/W channels.
// Ports:
//   clk   in  clock
//   rst   in  synchronous reset, active-high
//   stall in  valid & ~ready for the watched channel
//   clr   in  clears the counter and the sticky error
//   err   out sticky timeout flag
module easyaxi_stall_timer #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned TO_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clr,
    output logic err
);

    localparam logic [TO_W-1:0] LIMIT    = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] LIMIT_M1 = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            // Any non-stall cycle (handshake or idle) breaks the run of stalls.
            if (clr || !stall)
                cnt <= '0;
            else if (cnt != LIMIT)
                cnt <= cnt + 1'b1;

            // Set on the edge where the counter reaches LIMIT.
            if (clr)
                err <= 1'b0;
            else if (stall && cnt == LIMIT_M1)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/easyaxi_mst_ar.sv
// easyaxi_mst_ar
//   AXI read-address channel master. On start (with enable) issues REQ_NUM AR
//   requests with incrementing ID and address, holding valid/payload stable until
//   accepted, and flags a slave that stalls TIMEOUT_CYC consecutive cycles.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   enable           run permission (level); low aborts after the current handshake
//   start            one-cycle run request, honoured only in IDLE with enable
//   axi_mst_arvalid  AR valid
//   axi_mst_arready  AR ready from slave
//   axi_mst_arid     AR ID
//   axi_mst_araddr   AR address
//   busy             run in progress
//   done             one-cycle pulse when all REQ_NUM requests were accepted
//   timeout_err      sticky stall timeout flag
//   req_cnt          requests accepted in current/last run
module easyaxi_mst_ar
    import easyaxi_mst_ar_pkg::*;
#(
    parameter int unsigned                     AXI_ID_WIDTH   = EASYAXI_ID_WIDTH,
    parameter int unsigned                     AXI_ADDR_WIDTH = EASYAXI_ADDR_WIDTH,
    parameter int unsigned                     REQ_NUM        = 16,
    parameter int unsigned                     CNT_W          = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0]       ADDR_BASE      = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0]       ADDR_STEP      = AXI_ADDR_WIDTH'(4),
    parameter int unsigned                     TIMEOUT_CYC    = 64,
    parameter int unsigned                     TO_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      start,
    output logic                      axi_mst_arvalid,
    input  logic                      axi_mst_arready,
    output logic [AXI_ID_WIDTH-1:0]   axi_mst_arid,
    output logic [AXI_ADDR_WIDTH-1:0] axi_mst_araddr,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          req_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REQ_NUM);

    easyaxi_mst_state_e        state, state_n;
    logic                      arvalid_n;
    logic [AXI_ID_WIDTH-1:0]   arid_n;
    logic [AXI_ADDR_WIDTH-1:0] araddr_n;
    logic                      done_n;
    logic [CNT_W-1:0]          req_cnt_n;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      hs;
    logic                      start_ok;

    assign hs       = axi_mst_arvalid & axi_mst_arready;
    assign start_ok = (state == EASYAXI_MST_IDLE) & start & enable;
    assign cnt_inc  = req_cnt + 1'b1;
    assign busy     = (state == EASYAXI_MST_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= EASYAXI_MST_IDLE;
            axi_mst_arvalid <= 1'b0;
            axi_mst_arid    <= '0;
            axi_mst_araddr  <= '0;
            done            <= 1'b0;
            req_cnt         <= '0;
        end else begin
            state           <= state_n;
            axi_mst_arvalid <= arvalid_n;
            axi_mst_arid    <= arid_n;
            axi_mst_araddr  <= araddr_n;
            done            <= done_n;
            req_cnt         <= req_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        arvalid_n = axi_mst_arvalid;
        arid_n    = axi_mst_arid;
        araddr_n  = axi_mst_araddr;
        done_n    = 1'b0;
        req_cnt_n = req_cnt;
        unique case (state)
            EASYAXI_MST_IDLE: begin
                if (start_ok) begin
                    state_n   = EASYAXI_MST_ISSUE;
                    arvalid_n = 1'b1;
                    arid_n    = '0;
                    araddr_n  = ADDR_BASE;
                    req_cnt_n = '0;
                end
            end
            EASYAXI_MST_ISSUE: begin
                // Without a handshake everything holds; valid is never withdrawn.
                if (hs) begin
                    req_cnt_n = cnt_inc;
                    if (cnt_inc == LAST_CNT) begin
                        state_n   = EASYAXI_MST_IDLE;
                        arvalid_n = 1'b0;
                        done_n    = 1'b1;
                    end else if (!enable) begin
                        state_n   = EASYAXI_MST_IDLE;
                        arvalid_n = 1'b0;
                    end else begin
                        arid_n   = axi_mst_arid + 1'b1;
                        araddr_n = axi_mst_araddr + ADDR_STEP;
                    end
                end
            end
            default: state_n = EASYAXI_MST_IDLE;
        endcase
    end

    easyaxi_stall_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_stall_timer (
        .clk   (clk),
        .rst   (rst),
        .stall (axi_mst_arvalid & ~axi_mst_arready),
        .clr   (start_ok),
        .err   (timeout_err)
    );

endmodule
